// File: rtl/tinyalu_pkg.sv
// Shared types, widths and the reference prediction for the tinyalu datapath
// and its checker.
package tinyalu_pkg;

    localparam int RES_W = 16;
    localparam int OPD_W = 8;

    typedef enum logic [2:0] {
        NO_OP  = 3'd0,
        ADD_OP = 3'd1,
        AND_OP = 3'd2,
        XOR_OP = 3'd3,
        MUL_OP = 3'd4
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NOOP  = 2'd1,
        ST_BUSY  = 2'd2,
        ST_CHECK = 2'd3
    } chk_state_e;

    // Only these opcodes produce a result; every other encoding behaves as a no-op.
    function automatic logic is_alu_op(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd4);
    endfunction

    function automatic logic [RES_W-1:0] predict(
        input logic [2:0]       op,
        input logic [OPD_W-1:0] a,
        input logic [OPD_W-1:0] b
    );
        logic [RES_W-1:0] a_ext;
        logic [RES_W-1:0] b_ext;
        logic [RES_W-1:0] res;
        a_ext = {8'h00, a};
        b_ext = {8'h00, b};
        case (op)
            3'd1:    res = a_ext + b_ext;
            3'd2:    res = a_ext & b_ext;
            3'd3:    res = a_ext ^ b_ext;
            3'd4:    res = a_ext * b_ext;
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_predictor_comb.sv
// Combinational reference model: expected tinyalu result for an op and its
// operands.
module alu_predictor_comb
    import tinyalu_pkg::*;
(
    input  logic [2:0]       op,
    input  logic [OPD_W-1:0] a,
    input  logic [OPD_W-1:0] b,
    output logic [RES_W-1:0] result
);

    assign result = predict(op, a, b);

endmodule

// File: rtl/alu_checker.sv
// Drives tester commands onto the tinyalu pins, predicts the result, compares
// it with what the ALU returns and keeps saturating pass/fail counters.
//
//  state    | meaning
//  ---------+----------------------------------------------------------
//  IDLE     | ready for a command; alu_done here is a spurious done
//  NOOP     | one-cycle start pulse for no_op / undefined opcodes
//  BUSY     | start held with stable operands until done or timeout
//  CHECK    | verdict pulse on chk_valid, then back to IDLE
module alu_checker
    import tinyalu_pkg::*;
#(
    parameter int TIMEOUT = 32,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    output logic             alu_start,
    output logic [2:0]       alu_op,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    input  logic             alu_done,
    input  logic [15:0]      alu_result,
    output logic             chk_valid,
    output logic             chk_pass,
    output logic [15:0]      chk_expected,
    output logic [15:0]      chk_actual,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count
);

    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

    chk_state_e       state;
    logic [TMR_W-1:0] timer;
    logic [RES_W-1:0] expected;
    logic [RES_W-1:0] pred;
    logic             accept;
    logic             spurious;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

    alu_predictor_comb u_predictor (
        .op     (cmd_op),
        .a      (cmd_a),
        .b      (cmd_b),
        .result (pred)
    );

    assign accept   = cmd_valid & cmd_ready;
    assign spurious = alu_done & ((state == ST_IDLE) || (state == ST_NOOP));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            timer        <= '0;
            expected     <= '0;
            cmd_ready    <= 1'b1;
            alu_start    <= 1'b0;
            alu_op       <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            chk_valid    <= 1'b0;
            chk_pass     <= 1'b0;
            chk_expected <= '0;
            chk_actual   <= '0;
            pass_count   <= '0;
            fail_count   <= '0;
        end else begin
            chk_valid <= 1'b0;

            // A done with no operation outstanding is reported as a failure;
            // it never blocks a command accepted in the same cycle.
            if (spurious) begin
                chk_valid    <= 1'b1;
                chk_pass     <= 1'b0;
                chk_expected <= '0;
                chk_actual   <= alu_result;
                fail_count   <= sat_inc(fail_count);
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        alu_a     <= cmd_a;
                        alu_b     <= cmd_b;
                        expected  <= pred;
                        alu_start <= 1'b1;
                        cmd_ready <= 1'b0;
                        timer     <= TMR_LOAD;
                        if (is_alu_op(cmd_op)) begin
                            alu_op <= cmd_op;
                            state  <= ST_BUSY;
                        end else begin
                            alu_op <= NO_OP;
                            state  <= ST_NOOP;
                        end
                    end
                end

                ST_NOOP: begin
                    alu_start <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end

                ST_BUSY: begin
                    if (alu_done) begin
                        alu_start    <= 1'b0;
                        chk_valid    <= 1'b1;
                        chk_pass     <= (alu_result == expected);
                        chk_expected <= expected;
                        chk_actual   <= alu_result;
                        if (alu_result == expected) begin
                            pass_count <= sat_inc(pass_count);
                        end else begin
                            fail_count <= sat_inc(fail_count);
                        end
                        state <= ST_CHECK;
                    end else if (timer == '0) begin
                        alu_start    <= 1'b0;
                        chk_valid    <= 1'b1;
                        chk_pass     <= 1'b0;
                        chk_expected <= expected;
                        chk_actual   <= '1;
                        fail_count   <= sat_inc(fail_count);
                        state        <= ST_CHECK;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                ST_CHECK: begin
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end

                default: begin
                    alu_start <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_checker.sv
// Directed bench for alu_checker: the bench plays both command source and ALU.
module tb_alu_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic        alu_start;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        chk_valid;
    logic        chk_pass;
    logic [15:0] chk_expected;
    logic [15:0] chk_actual;
    logic [15:0] pass_count;
    logic [15:0] fail_count;

    int checks = 0;
    int errors = 0;

    alu_checker #(.TIMEOUT(32), .CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .alu_start    (alu_start),
        .alu_op       (alu_op),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_done     (alu_done),
        .alu_result   (alu_result),
        .chk_valid    (chk_valid),
        .chk_pass     (chk_pass),
        .chk_expected (chk_expected),
        .chk_actual   (chk_actual),
        .pass_count   (pass_count),
        .fail_count   (fail_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for cmd_ready, then presents the command for one edge.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready_timeout got %b want 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = 3'd0;
        cmd_a      = 8'h00;
        cmd_b      = 8'h00;
        alu_done   = 1'b0;
        alu_result = 16'h0000;
        step();
        step();
        checks++;
        if ({alu_start, alu_op, alu_a, alu_b, chk_valid, chk_pass} !== 21'h0) begin
            errors++;
            $display("FAIL reset_drive got %h want 0", {alu_start, alu_op, alu_a, alu_b, chk_valid, chk_pass});
        end
        checks++;
        if ({chk_expected, chk_actual, pass_count, fail_count} !== 64'h0) begin
            errors++;
            $display("FAIL reset_regs got %h want 0", {chk_expected, chk_actual, pass_count, fail_count});
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", cmd_ready);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_add();
        issue(3'd1, 8'hFF, 8'hFF);
        checks++;
        if ({alu_start, alu_op, alu_a, alu_b} !== {1'b1, 3'd1, 8'hFF, 8'hFF}) begin
            errors++;
            $display("FAIL add_drive got %h want %h", {alu_start, alu_op, alu_a, alu_b}, {1'b1, 3'd1, 8'hFF, 8'hFF});
        end
        alu_done   = 1'b1;
        alu_result = 16'h01FE;
        step();
        alu_done = 1'b0;
        checks++;
        if ({chk_valid, chk_pass, alu_start} !== 3'b110) begin
            errors++;
            $display("FAIL add_verdict got %b want 110", {chk_valid, chk_pass, alu_start});
        end
        checks++;
        if (chk_expected !== 16'h01FE || pass_count !== 16'd1 || fail_count !== 16'd0) begin
            errors++;
            $display("FAIL add_counts got exp=%h pass=%0d fail=%0d want 01fe 1 0", chk_expected, pass_count, fail_count);
        end
        step();
        checks++;
        if (chk_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_return got valid=%b ready=%b want 0 1", chk_valid, cmd_ready);
        end
    endtask

    task automatic test_mul();
        int hi = 0;
        issue(3'd4, 8'hFF, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            if (alu_start === 1'b1 && chk_valid === 1'b0) hi++;
            if (i == 2) begin
                alu_done   = 1'b1;
                alu_result = 16'hFE01;
            end
            step();
        end
        alu_done = 1'b0;
        checks++;
        if (hi != 3) begin
            errors++;
            $display("FAIL mul_start_cycles got %0d want 3", hi);
        end
        checks++;
        if ({chk_valid, chk_pass, alu_start} !== 3'b110 || chk_expected !== 16'hFE01 || pass_count !== 16'd2) begin
            errors++;
            $display("FAIL mul_verdict got v=%b p=%b s=%b exp=%h pass=%0d want 1 1 0 fe01 2",
                     chk_valid, chk_pass, alu_start, chk_expected, pass_count);
        end
    endtask

    task automatic test_xor_mismatch();
        issue(3'd3, 8'hA5, 8'h0F);
        alu_done   = 1'b1;
        alu_result = 16'h00AB;
        step();
        alu_done = 1'b0;
        checks++;
        if ({chk_valid, chk_pass} !== 2'b10 || chk_expected !== 16'h00AA || chk_actual !== 16'h00AB) begin
            errors++;
            $display("FAIL xor_verdict got v=%b p=%b exp=%h act=%h want 1 0 00aa 00ab",
                     chk_valid, chk_pass, chk_expected, chk_actual);
        end
        checks++;
        if (fail_count !== 16'd1 || pass_count !== 16'd2) begin
            errors++;
            $display("FAIL xor_counts got pass=%0d fail=%0d want 2 1", pass_count, fail_count);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        logic start_late = 1'b0;
        issue(3'd2, 8'hF0, 8'h3C);
        while (chk_valid !== 1'b1 && n < 100) begin
            step();
            n++;
            if (n == 31) start_late = alu_start;
        end
        checks++;
        if (n != 32) begin
            errors++;
            $display("FAIL timeout_cycles got %0d want 32", n);
        end
        checks++;
        if (start_late !== 1'b1) begin
            errors++;
            $display("FAIL timeout_start_held got %b want 1", start_late);
        end
        checks++;
        if ({chk_valid, chk_pass, alu_start} !== 3'b100 || chk_actual !== 16'hFFFF || chk_expected !== 16'h0030) begin
            errors++;
            $display("FAIL timeout_verdict got v=%b p=%b s=%b act=%h exp=%h want 1 0 0 ffff 0030",
                     chk_valid, chk_pass, alu_start, chk_actual, chk_expected);
        end
        checks++;
        if (fail_count !== 16'd2) begin
            errors++;
            $display("FAIL timeout_fail_count got %0d want 2", fail_count);
        end
    endtask

    task automatic test_noop();
        logic [2:0] ops [2];
        ops[0] = 3'd0;
        ops[1] = 3'd6;
        for (int k = 0; k < 2; k++) begin
            issue(ops[k], 8'h12, 8'h34);
            checks++;
            if ({alu_start, alu_op, chk_valid} !== {1'b1, 3'd0, 1'b0}) begin
                errors++;
                $display("FAIL noop_pulse op=%0d got s=%b op=%0d v=%b want 1 0 0", ops[k], alu_start, alu_op, chk_valid);
            end
            step();
            checks++;
            if ({alu_start, chk_valid, cmd_ready} !== 3'b001) begin
                errors++;
                $display("FAIL noop_end op=%0d got s=%b v=%b r=%b want 0 0 1", ops[k], alu_start, chk_valid, cmd_ready);
            end
        end
        checks++;
        if (pass_count !== 16'd2 || fail_count !== 16'd2) begin
            errors++;
            $display("FAIL noop_counts got pass=%0d fail=%0d want 2 2", pass_count, fail_count);
        end
    endtask

    task automatic test_spurious();
        alu_done   = 1'b1;
        alu_result = 16'h1234;
        cmd_valid  = 1'b1;
        cmd_op     = 3'd1;
        cmd_a      = 8'h10;
        cmd_b      = 8'h20;
        step();
        alu_done  = 1'b0;
        cmd_valid = 1'b0;
        checks++;
        if ({chk_valid, chk_pass} !== 2'b10 || chk_expected !== 16'h0000 || chk_actual !== 16'h1234 || fail_count !== 16'd3) begin
            errors++;
            $display("FAIL spurious_verdict got v=%b p=%b exp=%h act=%h fail=%0d want 1 0 0000 1234 3",
                     chk_valid, chk_pass, chk_expected, chk_actual, fail_count);
        end
        checks++;
        if ({alu_start, alu_op} !== {1'b1, 3'd1}) begin
            errors++;
            $display("FAIL spurious_accept got s=%b op=%0d want 1 1", alu_start, alu_op);
        end
        alu_done   = 1'b1;
        alu_result = 16'h0030;
        step();
        alu_done = 1'b0;
        checks++;
        if ({chk_valid, chk_pass} !== 2'b11 || chk_expected !== 16'h0030 || pass_count !== 16'd3) begin
            errors++;
            $display("FAIL spurious_followup got v=%b p=%b exp=%h pass=%0d want 1 1 0030 3",
                     chk_valid, chk_pass, chk_expected, pass_count);
        end
    endtask

    task automatic test_reset_mid_op();
        issue(3'd4, 8'h02, 8'h03);
        step();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({alu_start, cmd_ready, chk_valid} !== 3'b010 || pass_count !== 16'd0 || fail_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_op got s=%b r=%b v=%b pass=%0d fail=%0d want 0 1 0 0 0",
                     alu_start, cmd_ready, chk_valid, pass_count, fail_count);
        end
        step();
        reset = 1'b0;
        step();
        issue(3'd1, 8'h01, 8'h02);
        alu_done   = 1'b1;
        alu_result = 16'h0003;
        step();
        alu_done = 1'b0;
        checks++;
        if ({chk_valid, chk_pass} !== 2'b11 || chk_expected !== 16'h0003 || pass_count !== 16'd1 || fail_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_then_add got v=%b p=%b exp=%h pass=%0d fail=%0d want 1 1 0003 1 0",
                     chk_valid, chk_pass, chk_expected, pass_count, fail_count);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_xor_mismatch();
        test_timeout();
        test_noop();
        test_spurious();
        test_reset_mid_op();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
